// File: rtl/shared_buf_max_scheduler.sv
// Sequential max-occupancy scheduler: scans a snapshot of the per-port counters
// one port per cycle from a round-robin pointer and reports the largest eligible port.
module shared_buf_max_scheduler #(
  parameter int NUM_PORT = 16,
  parameter int PORT_W   = 5,
  parameter int CNT_W    = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_PORT*CNT_W-1:0] cnt_vec,
  input  logic [NUM_PORT-1:0]       port_en,
  input  logic                      req_valid,
  output logic                      req_ready,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [PORT_W-1:0]         res_port,
  output logic [CNT_W-1:0]          res_count,
  output logic                      res_none,
  output logic                      busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORT - 1);

  logic [1:0]                r_state;
  logic [NUM_PORT*CNT_W-1:0] r_snap_cnt;
  logic [NUM_PORT-1:0]       r_snap_en;
  logic [PORT_W-1:0]         r_idx;
  logic [PORT_W-1:0]         r_step;
  logic [PORT_W-1:0]         r_rr_ptr;
  logic                      r_best_found;
  logic [PORT_W-1:0]         r_best_port;
  logic [CNT_W-1:0]          r_best_cnt;
  logic                      r_res_valid;
  logic [PORT_W-1:0]         r_res_port;
  logic [CNT_W-1:0]          r_res_count;
  logic                      r_res_none;

  logic [CNT_W-1:0]  w_cur_cnt;
  logic              w_cur_en;
  logic              w_take;
  logic              w_new_found;
  logic [PORT_W-1:0] w_new_port;
  logic [CNT_W-1:0]  w_new_cnt;
  logic [PORT_W-1:0] w_idx_next;
  logic [PORT_W-1:0] w_rr_next;
  logic              w_scan_last;

  // Select the snapshot entry under the scan index; indices >= NUM_PORT never occur.
  always_comb begin
    w_cur_cnt = '0;
    w_cur_en  = 1'b0;
    for (int i = 0; i < NUM_PORT; i++) begin
      if (r_idx == PORT_W'(i)) begin
        w_cur_cnt = r_snap_cnt[i*CNT_W +: CNT_W];
        w_cur_en  = r_snap_en[i];
      end
    end
  end

  // Strictly-greater replacement keeps the earliest port in scan order on ties.
  assign w_take      = w_cur_en && (w_cur_cnt != '0) &&
                       (!r_best_found || (w_cur_cnt > r_best_cnt));
  assign w_new_found = r_best_found | w_take;
  assign w_new_port  = w_take ? r_idx : r_best_port;
  assign w_new_cnt   = w_take ? w_cur_cnt : r_best_cnt;
  assign w_idx_next  = (r_idx == LAST_PORT) ? '0 : r_idx + 1'b1;
  assign w_rr_next   = (r_res_port == LAST_PORT) ? '0 : r_res_port + 1'b1;
  assign w_scan_last = (r_step == LAST_PORT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_snap_cnt   <= '0;
      r_snap_en    <= '0;
      r_idx        <= '0;
      r_step       <= '0;
      r_rr_ptr     <= '0;
      r_best_found <= 1'b0;
      r_best_port  <= '0;
      r_best_cnt   <= '0;
      r_res_valid  <= 1'b0;
      r_res_port   <= '0;
      r_res_count  <= '0;
      r_res_none   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_snap_cnt   <= cnt_vec;
            r_snap_en    <= port_en;
            r_idx        <= r_rr_ptr;
            r_step       <= '0;
            r_best_found <= 1'b0;
            r_best_port  <= '0;
            r_best_cnt   <= '0;
            r_state      <= S_SCAN;
          end
        end
        S_SCAN: begin
          r_best_found <= w_new_found;
          r_best_port  <= w_new_port;
          r_best_cnt   <= w_new_cnt;
          r_idx        <= w_idx_next;
          r_step       <= r_step + 1'b1;
          // The last comparison folds straight into the result registers.
          if (w_scan_last) begin
            r_state     <= S_DONE;
            r_res_valid <= 1'b1;
            r_res_none  <= !w_new_found;
            r_res_port  <= w_new_found ? w_new_port : '0;
            r_res_count <= w_new_found ? w_new_cnt : '0;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
            if (!r_res_none) begin
              r_rr_ptr <= w_rr_next;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign res_valid = r_res_valid;
  assign res_port  = r_res_port;
  assign res_count = r_res_count;
  assign res_none  = r_res_none;

endmodule

// File: tb/tb_shared_buf_max_scheduler.sv
// Randomised and directed bench for shared_buf_max_scheduler against a
// max-then-first-at-or-after-pointer reference model.
module tb_shared_buf_max_scheduler;
  localparam int NP = 16;
  localparam int PW = 5;
  localparam int CW = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*CW-1:0]  cnt_vec;
  logic [NP-1:0]     port_en;
  logic              req_valid;
  logic              req_ready;
  logic              res_valid;
  logic              res_ready;
  logic [PW-1:0]     res_port;
  logic [CW-1:0]     res_count;
  logic              res_none;
  logic              busy;

  shared_buf_max_scheduler #(.NUM_PORT(NP), .PORT_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cnt_vec(cnt_vec), .port_en(port_en),
    .req_valid(req_valid), .req_ready(req_ready), .res_valid(res_valid),
    .res_ready(res_ready), .res_port(res_port), .res_count(res_count),
    .res_none(res_none), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] m_cnt [NP];
  logic [NP-1:0] m_en;
  int            m_rr;
  int            e_port;
  int            e_count;
  bit            e_none;
  int            o_port;
  int            o_count;
  bit            o_none;
  int            o_lat;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_inputs;
    for (int i = 0; i < NP; i++) cnt_vec[i*CW +: CW] = m_cnt[i];
    port_en = m_en;
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < NP; i++) m_cnt[i] = CW'(v);
    m_en = '1;
  endtask

  // Reference: largest eligible count, then first matching port at or after m_rr.
  function automatic void model;
    int maxv;
    maxv = 0;
    for (int p = 0; p < NP; p++)
      if (m_en[p] && int'(m_cnt[p]) > maxv) maxv = int'(m_cnt[p]);
    e_none  = (maxv == 0);
    e_port  = 0;
    e_count = maxv;
    if (!e_none) begin
      for (int k = NP - 1; k >= 0; k--) begin
        int p;
        p = (m_rr + k) % NP;
        if (m_en[p] && int'(m_cnt[p]) == maxv) e_port = p;
      end
    end
  endfunction

  function automatic void model_commit;
    if (!e_none) m_rr = (e_port + 1) % NP;
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_rr = 0;
  endtask

  task automatic accept_req;
    int w;
    drive_inputs();
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 50) begin
      tick();
      w++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_res;
    o_lat = 0;
    while (!res_valid && o_lat < 64) begin
      tick();
      o_lat++;
    end
    if (!res_valid) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: res_valid=%0b required 1", res_valid);
    end
    o_port  = int'(res_port);
    o_count = int'(res_count);
    o_none  = res_none;
    $display("txn rr=%0d port=%0d count=%0d none=%0b lat=%0d (model port=%0d count=%0d none=%0b)",
             m_rr, o_port, o_count, o_none, o_lat, e_port, e_count, e_none);
  endtask

  task automatic handoff;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic run_txn;
    model();
    accept_req();
    wait_res();
    handoff();
    model_commit();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_rr = 0;
    checks++;
    if ({req_ready, res_valid, res_none, busy} !== 4'b1000 || res_port !== '0 || res_count !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b vld=%0b none=%0b busy=%0b port=%0d cnt=%0d required 1 0 0 0 0 0",
               req_ready, res_valid, res_none, busy, res_port, res_count);
    end
    // Move rr_ptr off zero so the mid-scan reset has something to clear.
    fill(0);
    m_cnt[9] = 11'd70;
    run_txn();
    fill(10);
    accept_req();
    repeat (5) tick();
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL scan_busy: busy=%0b rdy=%0b required 1 0", busy, req_ready);
    end
    do_reset();
    checks++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || res_port !== '0) begin
      errors++;
      $display("FAIL reset_mid_scan: rdy=%0b vld=%0b busy=%0b port=%0d required 1 0 0 0",
               req_ready, res_valid, busy, res_port);
    end
    fill(0);
    m_cnt[2] = 11'd400; m_cnt[7] = 11'd400; m_cnt[12] = 11'd400;
    run_txn();
    checks++;
    if (o_port != 2) begin
      errors++;
      $display("FAIL reset_rr_ptr: port=%0d required 2", o_port);
    end
    // Reset while a result is being held.
    fill(0);
    m_cnt[4] = 11'd33;
    model();
    accept_req();
    wait_res();
    do_reset();
    checks++;
    if (res_valid !== 1'b0 || res_count !== '0 || res_port !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_done: vld=%0b cnt=%0d port=%0d busy=%0b required 0 0 0 0",
               res_valid, res_count, res_port, busy);
    end
  endtask

  task automatic test_basic;
    do_reset();
    fill(50);
    m_cnt[3] = 11'd100;
    m_cnt[9] = 11'd700;
    run_txn();
    checks++;
    if (o_port != 9 || o_count != 700 || o_none != 1'b0) begin
      errors++;
      $display("FAIL basic_max: port=%0d cnt=%0d none=%0b required 9 700 0", o_port, o_count, o_none);
    end
    // Result first visible in the cycle after the NUM_PORT-th scan edge.
    checks++;
    if (o_lat != NP) begin
      errors++;
      $display("FAIL basic_latency: edges=%0d required %0d", o_lat, NP);
    end
    fill(5);
    run_txn();
    checks++;
    if (o_port != 10) begin
      errors++;
      $display("FAIL basic_rr_after: port=%0d required 10", o_port);
    end
  endtask

  task automatic test_tie_rr;
    int exp_w [4];
    exp_w = '{2, 7, 12, 2};
    do_reset();
    fill(0);
    m_cnt[2] = 11'd400; m_cnt[7] = 11'd400; m_cnt[12] = 11'd400;
    for (int i = 0; i < 4; i++) begin
      run_txn();
      checks++;
      if (o_port != exp_w[i] || o_port != e_port || o_count != 400) begin
        errors++;
        $display("FAIL tie_rr_%0d: port=%0d cnt=%0d required %0d 400", i, o_port, o_count, exp_w[i]);
      end
    end
  endtask

  task automatic test_mask_none;
    fill(0);
    m_cnt[5] = 11'd2047;
    m_en[5]  = 1'b0;
    m_cnt[6] = 11'd10;
    run_txn();
    checks++;
    if (o_port != 6 || o_count != 10 || o_none != 1'b0) begin
      errors++;
      $display("FAIL mask_disabled: port=%0d cnt=%0d none=%0b required 6 10 0", o_port, o_count, o_none);
    end
    m_en = '1;
    run_txn();
    checks++;
    if (o_port != 5 || o_count != 2047) begin
      errors++;
      $display("FAIL mask_maxval: port=%0d cnt=%0d required 5 2047", o_port, o_count);
    end
    fill(0);
    run_txn();
    checks++;
    if (o_none != 1'b1 || o_port != 0 || o_count != 0) begin
      errors++;
      $display("FAIL none_result: none=%0b port=%0d cnt=%0d required 1 0 0", o_none, o_port, o_count);
    end
    fill(1);
    run_txn();
    checks++;
    if (o_port != 6) begin
      errors++;
      $display("FAIL none_rr_kept: port=%0d required 6", o_port);
    end
  endtask

  task automatic test_snapshot_bp;
    for (int i = 0; i < NP; i++) m_cnt[i] = CW'($urandom_range(1, 1500));
    m_cnt[1] = 11'd0;
    m_en = '1;
    model();
    accept_req();
    m_cnt[1] = 11'd2000;
    drive_inputs();
    tick();
    tick();
    req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL scan_req_ready: rdy=%0b required 0", req_ready);
    end
    tick();
    req_valid = 1'b0;
    wait_res();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (res_valid !== 1'b1 || req_ready !== 1'b0 || int'(res_port) != e_port ||
          int'(res_count) != e_count || res_none !== e_none) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: vld=%0b rdy=%0b port=%0d cnt=%0d required 1 0 %0d %0d",
                 c, res_valid, req_ready, res_port, res_count, e_port, e_count);
      end
      tick();
    end
    handoff();
    model_commit();
    tick();
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL scan_pulse_ignored: busy=%0b rdy=%0b required 0 1", busy, req_ready);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    fill(0);
    m_cnt[13] = 11'd5;
    run_txn();
    fill(0);
    m_cnt[15] = 11'd300;
    m_cnt[0]  = 11'd300;
    run_txn();
    checks++;
    if (o_port != 15 || o_count != 300) begin
      errors++;
      $display("FAIL wrap_winner: port=%0d cnt=%0d required 15 300", o_port, o_count);
    end
    run_txn();
    checks++;
    if (o_port != 0) begin
      errors++;
      $display("FAIL wrap_rr_zero: port=%0d required 0", o_port);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NP; i++) begin
        case ($urandom_range(0, 3))
          0: m_cnt[i] = '0;
          1: m_cnt[i] = 11'd2047;
          2: m_cnt[i] = CW'($urandom_range(0, 3));
          default: m_cnt[i] = CW'($urandom);
        endcase
      end
      m_en = NP'($urandom);
      if (n % 8 == 0) m_en = '1;
      model();
      accept_req();
      wait_res();
      repeat ($urandom_range(0, 3)) tick();
      handoff();
      model_commit();
      checks++;
      if (o_port != e_port || o_count != e_count || o_none != e_none || o_lat != NP) begin
        errors++;
        $display("FAIL random_%0d: port=%0d cnt=%0d none=%0b lat=%0d required %0d %0d %0b %0d",
                 n, o_port, o_count, o_none, o_lat, e_port, e_count, e_none, NP);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    res_ready = 1'b0;
    cnt_vec   = '0;
    port_en   = '0;
    m_rr      = 0;
    test_reset();
    test_basic();
    test_tie_rr();
    test_mask_none();
    test_snapshot_bp();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
